// File: rtl/comparator_nb_seq_if.sv
// comparator_nb_seq_if: handshake and operand/result bundle for comparator_nb_seq.
//   master : drives start, A, B (and SGN), observes busy, done, G, L, E
//   slave  : the comparator side
// WIDTH must match the WIDTH of the comparator instance it connects to.
// Optional: COMPARATOR_SIGNED_EN adds the SGN (two's-complement select) signal.
interface comparator_nb_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
`ifdef COMPARATOR_SIGNED_EN
  logic             SGN;
`endif
  logic             busy;
  logic             done;
  logic             G;
  logic             L;
  logic             E;

`ifdef COMPARATOR_SIGNED_EN
  modport master (output start, A, B, SGN, input busy, done, G, L, E);
  modport slave  (input start, A, B, SGN, output busy, done, G, L, E);
`else
  modport master (output start, A, B, input busy, done, G, L, E);
  modport slave  (input start, A, B, output busy, done, G, L, E);
`endif
endinterface

// File: rtl/comparator_nb_seq.sv
// comparator_nb_seq: sequential magnitude comparator. Compares two WIDTH-bit
// operands MSB-first, CHUNK bits per clock, stopping at the first differing
// chunk. Results are registered one-hot G/L/E, held until the next completion.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - comparator_nb_seq_if.slave: start, A, B, [SGN] in; busy, done, G, L, E out
// Optional: COMPARATOR_SIGNED_EN enables SGN; SGN=1 at start selects a
// two's-complement compare by flipping the sign bit of both operands on load.
module comparator_nb_seq #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  comparator_nb_seq_if.slave   bus
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N + 1) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             g_q, g_d;
  logic             l_q, l_d;
  logic             e_q, e_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] a_load_s;
  logic [WIDTH-1:0] b_load_s;
  logic [CHUNK-1:0] a_top_s;
  logic [CHUNK-1:0] b_top_s;

`ifdef COMPARATOR_SIGNED_EN
  // Flipping the sign bit maps two's-complement order onto unsigned order.
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};
  assign a_load_s = bus.SGN ? (bus.A ^ MSB_MASK) : bus.A;
  assign b_load_s = bus.SGN ? (bus.B ^ MSB_MASK) : bus.B;
`else
  assign a_load_s = bus.A;
  assign b_load_s = bus.B;
`endif

  assign a_top_s = a_q[WIDTH-1 -: CHUNK];
  assign b_top_s = b_q[WIDTH-1 -: CHUNK];

  // Next-state, shift-register and result logic for the IDLE/RUN/DONE FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    g_d     = g_q;
    l_d     = l_q;
    e_d     = e_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          a_d     = a_load_s;
          b_d     = b_load_s;
          cnt_d   = CW'(N);
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (a_top_s != b_top_s) begin
          g_d     = (a_top_s > b_top_s);
          l_d     = (a_top_s < b_top_s);
          e_d     = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (cnt_q == CW'(1)) begin
          g_d     = 1'b0;
          l_d     = 1'b0;
          e_d     = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          a_d   = a_q << CHUNK;
          b_d   = b_q << CHUNK;
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_RUN);
  end

  // Control and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= {CW{1'b0}};
      g_q     <= 1'b0;
      l_q     <= 1'b0;
      e_q     <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      g_q     <= g_d;
      l_q     <= l_d;
      e_q     <= e_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Operand shift registers carry no reset; their contents matter only in RUN.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.G    = g_q;
  assign bus.L    = l_q;
  assign bus.E    = e_q;

endmodule

// File: tb/tb_comparator_nb_seq.sv
// tb_comparator_nb_seq: self-checking bench for comparator_nb_seq with three
// instances (8/2, 16/16, 16/1) against a transaction-level reference model.
// Signed-mode cases run only when COMPARATOR_SIGNED_EN is defined.
module tb_comparator_nb_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_s [3];
  logic [15:0] a_s     [3];
  logic [15:0] b_s     [3];
  logic        sgn_s   [3];
  logic        busy_o  [3];
  logic        done_o  [3];
  logic        g_o     [3];
  logic        l_o     [3];
  logic        e_o     [3];

  int W [3] = '{8, 16, 16};
  int C [3] = '{2, 16, 1};

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  comparator_nb_seq_if #(.WIDTH(8))  if0 ();
  comparator_nb_seq_if #(.WIDTH(16)) if1 ();
  comparator_nb_seq_if #(.WIDTH(16)) if2 ();

  comparator_nb_seq #(.WIDTH(8),  .CHUNK(2))  u0 (.clk(clk), .rst(rst), .bus(if0.slave));
  comparator_nb_seq #(.WIDTH(16), .CHUNK(16)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
  comparator_nb_seq #(.WIDTH(16), .CHUNK(1))  u2 (.clk(clk), .rst(rst), .bus(if2.slave));

  assign if0.start = start_s[0];
  assign if0.A     = a_s[0][7:0];
  assign if0.B     = b_s[0][7:0];
  assign if1.start = start_s[1];
  assign if1.A     = a_s[1];
  assign if1.B     = b_s[1];
  assign if2.start = start_s[2];
  assign if2.A     = a_s[2];
  assign if2.B     = b_s[2];
`ifdef COMPARATOR_SIGNED_EN
  assign if0.SGN = sgn_s[0];
  assign if1.SGN = sgn_s[1];
  assign if2.SGN = sgn_s[2];
`endif

  assign busy_o[0] = if0.busy; assign done_o[0] = if0.done;
  assign g_o[0] = if0.G; assign l_o[0] = if0.L; assign e_o[0] = if0.E;
  assign busy_o[1] = if1.busy; assign done_o[1] = if1.done;
  assign g_o[1] = if1.G; assign l_o[1] = if1.L; assign e_o[1] = if1.E;
  assign busy_o[2] = if2.busy; assign done_o[2] = if2.done;
  assign g_o[2] = if2.G; assign l_o[2] = if2.L; assign e_o[2] = if2.E;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Index (1-based, from MSB) of the first differing chunk; N when equal.
  function automatic int exp_k(input int w, input int c, input logic [15:0] a, input logic [15:0] b);
    longint unsigned m;
    m = (64'd1 << c) - 64'd1;
    for (int i = 1; i <= w / c; i++) begin
      int sh;
      sh = w - i * c;
      if (((longint'(a) >> sh) & m) != ((longint'(b) >> sh) & m)) return i;
    end
    return w / c;
  endfunction

  // Reference relation {G,L,E} computed numerically.
  function automatic logic [2:0] exp_gle(input int w, input logic [15:0] a, input logic [15:0] b, input bit sg);
    longint m, va, vb;
    m  = (longint'(1) << w) - 1;
    va = longint'(a) & m;
    vb = longint'(b) & m;
    if (sg) begin
      if (va >= (longint'(1) << (w - 1))) va = va - (longint'(1) << w);
      if (vb >= (longint'(1) << (w - 1))) vb = vb - (longint'(1) << w);
    end
    return {va > vb, va < vb, va == vb};
  endfunction

  // Transaction-level model: on acceptance compute result and latency up front.
  bit         m_busy [3];
  bit         m_done [3];
  logic [2:0] m_gle  [3];
  logic [2:0] m_pend [3];
  int         m_rem  [3];

  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        m_busy[d] = 1'b0; m_done[d] = 1'b0; m_gle[d] = 3'b000; m_rem[d] = 0;
      end else if (!m_busy[d]) begin
        m_done[d] = 1'b0;
        if (start_s[d]) begin
          bit sg;
          sg = 1'b0;
`ifdef COMPARATOR_SIGNED_EN
          sg = sgn_s[d];
`endif
          m_pend[d] = exp_gle(W[d], a_s[d], b_s[d], sg);
          m_rem[d]  = exp_k(W[d], C[d], a_s[d], b_s[d]);
          m_busy[d] = 1'b1;
        end
      end else begin
        m_rem[d]--;
        if (m_rem[d] == 0) begin
          m_busy[d] = 1'b0; m_done[d] = 1'b1; m_gle[d] = m_pend[d];
        end
      end
    end
  end

  // Cycle-by-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("busy%0d", d), 32'(busy_o[d]), 32'(m_busy[d]));
        chk($sformatf("done%0d", d), 32'(done_o[d]), 32'(m_done[d]));
        chk($sformatf("gle%0d", d), 32'({g_o[d], l_o[d], e_o[d]}), 32'(m_gle[d]));
      end
    end
  end

  task automatic go(input int d, input logic [15:0] a, input logic [15:0] b, input logic sg,
                    input bit scr, output int lat, output logic [2:0] gle);
    @(negedge clk);
    start_s[d] = 1'b1; a_s[d] = a; b_s[d] = b; sgn_s[d] = sg;
    @(negedge clk);
    start_s[d] = 1'b0;
    lat = 0;
    while (!done_o[d] && lat < 40) begin
      if (scr) begin
        a_s[d] = 16'($urandom); b_s[d] = 16'($urandom); sgn_s[d] = ~sgn_s[d];
        start_s[d] = ~start_s[d];
      end
      @(negedge clk);
      lat++;
    end
    start_s[d] = 1'b0;
    if (lat >= 40) chk("done_timeout", 32'(lat), 32'(0));
    gle = {g_o[d], l_o[d], e_o[d]};
  endtask

  int         lat;
  logic [2:0] gle;

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      start_s[d] = 1'b0; a_s[d] = 16'h0000; b_s[d] = 16'h0000; sgn_s[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_busy", 32'(busy_o[0]), 32'd0);
    chk("rst_done", 32'(done_o[0]), 32'd0);
    chk("rst_gle", 32'({g_o[0], l_o[0], e_o[0]}), 32'd0);

    go(0, 16'h00A5, 16'h00A5, 1'b0, 1'b0, lat, gle);
    chk("eq_lat", 32'(lat), 32'd4); chk("eq_gle", 32'(gle), 32'b001);
    go(0, 16'h0080, 16'h007F, 1'b0, 1'b0, lat, gle);
    chk("gt_lat", 32'(lat), 32'd1); chk("gt_gle", 32'(gle), 32'b100);
    go(0, 16'h0012, 16'h0013, 1'b0, 1'b0, lat, gle);
    chk("lt_lat", 32'(lat), 32'd4); chk("lt_gle", 32'(gle), 32'b010);
    repeat (3) @(negedge clk);
    chk("hold_gle", 32'({g_o[0], l_o[0], e_o[0]}), 32'b010);
    go(0, 16'h00C3, 16'h00C1, 1'b0, 1'b1, lat, gle);
    chk("scr_lat", 32'(lat), 32'd4); chk("scr_gle", 32'(gle), 32'b100);

`ifdef COMPARATOR_SIGNED_EN
    go(0, 16'h0080, 16'h007F, 1'b1, 1'b0, lat, gle);
    chk("s_neg_lat", 32'(lat), 32'd1); chk("s_neg_gle", 32'(gle), 32'b010);
    go(0, 16'h00FF, 16'h00FE, 1'b1, 1'b0, lat, gle);
    chk("s_m1_lat", 32'(lat), 32'd4); chk("s_m1_gle", 32'(gle), 32'b100);
    go(0, 16'h00FF, 16'h00FE, 1'b0, 1'b0, lat, gle);
    chk("u_ff_gle", 32'(gle), 32'b100);
`endif

    // Back-to-back acceptance with start held high.
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      start_s[0] = 1'b1;
      a_s[0] = 16'($urandom_range(0, 255));
      b_s[0] = (i % 2 == 0) ? a_s[0] : 16'($urandom_range(0, 255));
    end
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (6) @(negedge clk);

    // Reset in the middle of an equal-operand compare.
    start_s[0] = 1'b1; a_s[0] = 16'h00A5; b_s[0] = 16'h00A5; sgn_s[0] = 1'b0;
    @(negedge clk);
    start_s[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_busy", 32'(busy_o[0]), 32'd0);
    chk("mrst_done", 32'(done_o[0]), 32'd0);
    chk("mrst_gle", 32'({g_o[0], l_o[0], e_o[0]}), 32'd0);
    @(negedge clk);
    chk("mrst_nodone", 32'(done_o[0]), 32'd0);
    go(0, 16'h0012, 16'h0013, 1'b0, 1'b0, lat, gle);
    chk("post_lat", 32'(lat), 32'd4); chk("post_gle", 32'(gle), 32'b010);

    go(2, 16'h8000, 16'h0000, 1'b0, 1'b0, lat, gle);
    chk("b1_msb_lat", 32'(lat), 32'd1); chk("b1_msb_gle", 32'(gle), 32'b100);
    go(2, 16'h1234, 16'h1234, 1'b0, 1'b0, lat, gle);
    chk("b1_eq_lat", 32'(lat), 32'd16); chk("b1_eq_gle", 32'(gle), 32'b001);
    go(2, 16'h0001, 16'h0000, 1'b0, 1'b0, lat, gle);
    chk("b1_lsb_lat", 32'(lat), 32'd16); chk("b1_lsb_gle", 32'(gle), 32'b100);
    go(1, 16'h0001, 16'h0002, 1'b0, 1'b0, lat, gle);
    chk("w16_lat", 32'(lat), 32'd1); chk("w16_gle", 32'(gle), 32'b010);

    // Randomized traffic on all instances, including mid-RUN changes.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        int mode;
        start_s[d] = 1'($urandom_range(0, 1));
        a_s[d] = 16'($urandom);
        mode = $urandom_range(0, 2);
        if (mode == 0)      b_s[d] = 16'($urandom);
        else if (mode == 1) b_s[d] = a_s[d];
        else                b_s[d] = a_s[d] ^ (16'h0001 << $urandom_range(0, W[d] - 1));
`ifdef COMPARATOR_SIGNED_EN
        sgn_s[d] = 1'($urandom_range(0, 1));
`endif
      end
    end
    for (int d = 0; d < 3; d++) start_s[d] = 1'b0;
    repeat (20) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
